// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin owner selection for one shared resource.
// Ownership ends on done, request withdrawal or hold timeout.
module rr_grant_scheduler #(
  parameter int N        = 4,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            busy,
  output logic            timeout
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0]      state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] idx;
  logic [7:0]      hold_cnt;
  logic            found;
  logic            withdrawn;
  logic            expired;
  logic            release_now;
  // Scan ptr, ptr+1, ... relying on IDXW-bit wrap since N is a power of 2
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + IDXW'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
  assign withdrawn   = !req[grant_idx];
  assign expired     = hold_cnt == 8'(MAX_HOLD - 1);
  assign release_now = done || withdrawn || expired;
  assign busy        = state == GRANT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else if (state == IDLE) begin
      timeout <= 1'b0;
      if (found) begin
        state     <= GRANT;
        grant_idx <= sel;
        grant     <= N'(1) << sel;
        hold_cnt  <= '0;
      end
    end else if (release_now) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= grant_idx + 1'b1;
      timeout <= expired && !done && !withdrawn;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: directed and randomized checks against a cycle-level ownership model.
module tb_rr_grant_scheduler;
  localparam int N = 4;
  localparam int IDXW = 2;
  localparam int MAX_HOLD = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic busy;
  logic timeout;
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int m_ptr = 0, m_owner = 0, m_age = 0;
  bit m_busy = 1'b0, m_to = 1'b0;

  rr_grant_scheduler #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: age counts cycles the grant has been visible
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_age = 0; m_busy = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (req != 0) begin
          int pick;
          pick = -1;
          for (int k = 0; k < N; k++)
            if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
          m_owner = pick; m_busy = 1; m_age = 1;
        end
      end else begin
        bit d, w, t;
        d = done; w = !req[m_owner]; t = (m_age == MAX_HOLD);
        if (d || w || t) begin
          m_busy = 0;
          m_ptr = (m_owner + 1) % N;
          m_to = t && !d && !w;
        end else m_age++;
      end
    end
  end

  always @(negedge clk) if (cmp_en) begin
    chk("grant", grant, m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("grant_idx", grant_idx, m_owner);
    chk("busy", busy, m_busy);
    chk("timeout", timeout, m_to);
  end

  task automatic settle();
    req = '0; done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] q[$];
    bit pb;
    int n;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_grant", grant, 0);
      chk("idle_busy", busy, 0);
      chk("idle_idx", grant_idx, 0);
      chk("idle_timeout", timeout, 0);
    end
    req = 4'b1111; pb = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy && !pb) q.push_back(grant);
      pb = busy;
      done = m_busy && m_age == 2;
      if (i == 11) req = 4'b0001;
    end
    chk("rr_count", q.size(), 5);
    if (q.size() == 5) begin
      chk("rr0", q[0], 4'b0001);
      chk("rr1", q[1], 4'b0010);
      chk("rr2", q[2], 4'b0100);
      chk("rr3", q[3], 4'b1000);
      chk("rr_wrap", q[4], 4'b0001);
    end
    settle();
    req = 4'b0100;
    @(negedge clk);
    n = 0;
    while (grant == 4'b0100 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("hold_len", n, MAX_HOLD);
    chk("to_pulse", timeout, 1);
    chk("to_busy", busy, 0);
    @(negedge clk);
    chk("regrant", grant, 4'b0100);
    chk("to_once", timeout, 0);
    repeat (7) @(negedge clk);
    chk("last_hold_cycle", grant, 4'b0100);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("done_vs_to_busy", busy, 0);
    chk("done_vs_to_timeout", timeout, 0);
    settle();
    req = 4'b0100;
    repeat (2) @(negedge clk);
    chk("pre_withdraw", grant, 4'b0100);
    req = 4'b0000;
    @(negedge clk);
    chk("withdraw_grant", grant, 0);
    chk("withdraw_timeout", timeout, 0);
    settle();
    req = 4'b0010;
    @(negedge clk);
    chk("pre_rst_grant", grant, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_idx", grant_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    @(negedge clk);
    chk("post_rst_grant", grant, 4'b0010);
    chk("post_rst_idx", grant_idx, 1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      done = ($urandom_range(0, 11) == 0);
      if (i == 1500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one resource among N requesters.
- Emits the owner index (grant_idx) and its one-hot decoded form (grant = 1 << grant_idx), so downstream enables are driven by a decoder-equivalent output.
- Ownership ends on done, on request withdrawal, or on a hold timeout.
- Sits between requesting units and the shared datapath/bus select logic.

Parameters:
- N, 4, number of requesters; power of 2, 2..16.
- IDXW, $clog2(N), width of grant_idx.
- MAX_HOLD, 8, maximum cycles a grant may be held; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  request vector; bit i = requester i wants the resource.
- done  input  1  current owner finished; sampled only while busy.
- grant  output  N  one-hot grant; all-zero when idle.
- grant_idx  output  IDXW  index of current/last owner.
- busy  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (async, immediate): all outputs are zero (grant, grant_idx, busy, timeout), ptr=0, hold_cnt=0, state=IDLE. Reset mid-grant drops grant combinationally with rst; no done/timeout is generated.
- All outputs are registered; grant == (busy ? 1<<grant_idx : 0) at all times.
- State IDLE:
  - if req != 0 at an edge, select the first set bit scanning ptr, ptr+1, ..., wrapping N-1 -> 0.
  - At that edge: state=GRANT, grant_idx=selected, busy=1, hold_cnt=0.
  - Latency: req high before edge k gives grant visible after edge k.
  - done is ignored in IDLE.
- State GRANT: release at the edge where any of the following holds:
  - (a) done=1
  - (b) req[grant_idx]=0
  - (c) hold_cnt == MAX_HOLD-1
- Otherwise hold_cnt increments.
- On release:
  - state=IDLE, busy=0, grant=0.
  - ptr=(grant_idx+1) mod N; wrap-around is required.
  - grant_idx retains the last owner.
- timeout=1 for exactly one cycle only when release is due to (c) and neither (a) nor (b) holds at that edge.
- Precedence: done or req withdrawal beats timeout in the same cycle.
- Grant duration:
  - without done or req withdrawal, grant is high exactly MAX_HOLD cycles.
  - MAX_HOLD=1 gives single-cycle grants.
- One mandatory idle cycle (busy=0) separates consecutive grants. A new selection occurs at the edge after release, using the updated ptr.
- Requests from other requesters arriving during GRANT are never preemptive; they are evaluated only in IDLE.
- Fairness: with all N requesting continuously, grants cycle 0,1,...,N-1,0. No requester waits more than N-1 other grants.
- req bits that toggle while not owner have no effect; nothing is latched.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0000, busy=0, grant_idx=0, timeout=0 throughout.
- req=4'b1111 held, done pulsed on the 2nd grant cycle of each grant -> grant sequence 0001,0010,0100,1000,0001. Each grant lasts 2 cycles, with 1 idle cycle between grants.
- After owner 3, req=4'b0001 only, with done -> grant returns to 0001. This checks ptr wrap 3 -> 0.
- req=4'b0100, done never asserted, MAX_HOLD=8 -> grant=0100 for exactly 8 cycles, then timeout=1 for 1 cycle with busy=0, then regrant 0100 after the idle cycle.
- done=1 on the same edge as hold_cnt=MAX_HOLD-1 -> release with timeout=0. Separately: req[owner] dropped mid-grant -> grant cleared at the next edge, timeout=0.
- rst asserted asynchronously mid-grant (grant=0010) -> grant=0000 and busy=0 without waiting for an edge. After rst release with req=4'b1010 -> first grant 0010, since ptr=0 and the scan finds bit 1.
